fir_tap_accumulator: RTL and testbench

Sums one output sample's worth of 16-bit signed tap products for the FIR filter. It sits directly downstream of the tap multipliers and upstream of the output register. The low 16 bits go through the team's 16-bit hierarchical carry-lookahead adder, and a 4-bit guard extension absorbs growth. It accepts NTAPS products per frame over a valid/ready handshake, then presents one saturated 16-bit result with an overflow flag.

---
 rtl/fir_pkg.sv | 36 +++
 rtl/Hiera_CLA.sv | 60 ++++++
 rtl/fir_tap_accumulator.sv | 94 +++++++++
 tb/tb_fir_tap_accumulator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared widths, saturation limits and state encoding for the FIR
//            tap accumulator.
// Revision : 1.0
// ============================================================================
package fir_pkg;

   localparam int DATA_W  = 16;
   localparam int GUARD_W = 4;
   localparam int ACC_W   = DATA_W + GUARD_W;

   localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

   typedef enum logic [0:0] {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Returns {ovf, data}. The value fits 16 signed bits only when the guard
   // bits are a pure sign extension of bit 15.
   function automatic logic [DATA_W:0] saturate(input logic [ACC_W-1:0] acc);
      logic [GUARD_W:0] top;
      top = acc[ACC_W-1:DATA_W-1];
      if (top == '0 || top == '1)
         saturate = {1'b0, acc[DATA_W-1:0]};
      else if (!acc[ACC_W-1])
         saturate = {1'b1, SAT_MAX};
      else
         saturate = {1'b1, SAT_MIN};
   endfunction

endpackage
`default_nettype wire

// File: rtl/Hiera_CLA.sv
`default_nettype none
// ============================================================================
// Module   : Hiera_CLA
// Brief    : 16-bit two-level carry-lookahead adder (four 4-bit groups).
// Revision : 1.0
// ============================================================================
module Hiera_CLA
   import fir_pkg::*;
(
   input  logic [DATA_W-1:0] add_1,
   input  logic [DATA_W-1:0] add_2,
   input  logic              c_in,
   output logic [DATA_W-1:0] sum,
   output logic              c_out
);

   logic [DATA_W-1:0] w_g;
   logic [DATA_W-1:0] w_p;
   logic [DATA_W-1:0] w_c;
   logic [3:0]        w_gg;
   logic [3:0]        w_gp;
   logic [3:0]        w_gc;

   assign w_g = add_1 & add_2;
   assign w_p = add_1 ^ add_2;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_grp
         logic [3:0] w_lg;
         logic [3:0] w_lp;
         assign w_lg = w_g[4*gi +: 4];
         assign w_lp = w_p[4*gi +: 4];

         assign w_gg[gi] = w_lg[3] | (w_lp[3] & w_lg[2]) | (w_lp[3] & w_lp[2] & w_lg[1])
                         | (w_lp[3] & w_lp[2] & w_lp[1] & w_lg[0]);
         assign w_gp[gi] = &w_lp;

         assign w_c[4*gi+0] = w_gc[gi];
         assign w_c[4*gi+1] = w_lg[0] | (w_lp[0] & w_gc[gi]);
         assign w_c[4*gi+2] = w_lg[1] | (w_lp[1] & w_lg[0]) | (w_lp[1] & w_lp[0] & w_gc[gi]);
         assign w_c[4*gi+3] = w_lg[2] | (w_lp[2] & w_lg[1]) | (w_lp[2] & w_lp[1] & w_lg[0])
                            | (w_lp[2] & w_lp[1] & w_lp[0] & w_gc[gi]);
      end
   endgenerate

   // Second-level lookahead over the group generate/propagate terms.
   assign w_gc[0] = c_in;
   assign w_gc[1] = w_gg[0] | (w_gp[0] & c_in);
   assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c_in);
   assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & c_in);
   assign c_out   = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & c_in);

   assign sum = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/fir_tap_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_accumulator
// Brief    : Sums NTAPS signed 16-bit products into a saturated 16-bit result.
// Revision : 1.0
// ============================================================================
module fir_tap_accumulator
   import fir_pkg::*;
#(
   parameter int NTAPS = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ovf
);

   localparam int              TAP_W  = $clog2(NTAPS);
   localparam logic [TAP_W-1:0] c_last = TAP_W'(NTAPS - 1);

   state_t             r_state;
   logic [DATA_W-1:0]  r_acc_lo;
   logic [GUARD_W-1:0] r_acc_hi;
   logic [TAP_W-1:0]   r_tap_cnt;
   logic [DATA_W-1:0]  r_out_data;
   logic               r_out_ovf;

   logic               w_accept;
   logic [DATA_W-1:0]  w_lo_sum;
   logic               w_lo_cout;
   logic [GUARD_W-1:0] w_hi_sum;
   logic [DATA_W:0]    w_sat;

   assign in_ready  = (r_state == ACC) && rst_n;
   assign out_valid = (r_state == HOLD);
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;
   assign w_accept  = in_valid && in_ready;

   Hiera_CLA u_cla (
      .add_1 (r_acc_lo),
      .add_2 (in_data),
      .c_in  (1'b0),
      .sum   (w_lo_sum),
      .c_out (w_lo_cout)
   );

   // Guard bits take the sign extension of the product plus the CLA carry.
   assign w_hi_sum = r_acc_hi + {GUARD_W{in_data[DATA_W-1]}}
                   + {{(GUARD_W-1){1'b0}}, w_lo_cout};
   assign w_sat    = saturate({w_hi_sum, w_lo_sum});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ACC;
         r_acc_lo   <= '0;
         r_acc_hi   <= '0;
         r_tap_cnt  <= '0;
         r_out_data <= '0;
         r_out_ovf  <= 1'b0;
      end else begin
         case (r_state)
            ACC: begin
               if (w_accept) begin
                  if (r_tap_cnt == c_last) begin
                     r_out_data <= w_sat[DATA_W-1:0];
                     r_out_ovf  <= w_sat[DATA_W];
                     r_acc_lo   <= '0;
                     r_acc_hi   <= '0;
                     r_tap_cnt  <= '0;
                     r_state    <= HOLD;
                  end else begin
                     r_acc_lo   <= w_lo_sum;
                     r_acc_hi   <= w_hi_sum;
                     r_tap_cnt  <= r_tap_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready)
                  r_state <= ACC;
            end
            default: r_state <= ACC;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_tap_accumulator
// Brief    : Randomized self-checking bench for fir_tap_accumulator (NTAPS=4).
// Revision : 1.0
// ============================================================================
module tb_fir_tap_accumulator;

   localparam int NTAPS = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_ovf;

   int n_checks;
   int n_errors;

   fir_tap_accumulator #(.NTAPS(NTAPS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: exact integer sum clipped to the signed 16-bit range.
   function automatic logic [16:0] ref_result(input logic [15:0] v [NTAPS]);
      int s;
      s = 0;
      for (int i = 0; i < NTAPS; i++) s += int'($signed(v[i]));
      if (s > 32767)       ref_result = {1'b1, 16'h7FFF};
      else if (s < -32768) ref_result = {1'b1, 16'h8000};
      else                 ref_result = {1'b0, s[15:0]};
   endfunction

   task automatic send_product(input logic [15:0] v, input bit gaps);
      int waited;
      if (gaps) begin
         for (int k = 0; k < 8 && $urandom_range(1) == 1; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'($urandom);
         end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check_val("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] v [NTAPS], input bit gaps);
      for (int i = 0; i < NTAPS; i++) begin
         send_product(v[i], gaps);
         check_val("valid_after_accept", 32'(out_valid), 32'(i == NTAPS - 1));
      end
   endtask

   task automatic get_result(input string tag, input logic [16:0] exp, input int delay);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!out_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
      for (int k = 0; k < delay; k++) @(negedge clk);
      check_val({tag, "_data"}, 32'(out_data), 32'(exp[15:0]));
      check_val({tag, "_ovf"},  32'(out_ovf),  32'(exp[16]));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_val({tag, "_released"}, 32'(out_valid), 32'd0);
      check_val({tag, "_ready_again"}, 32'(in_ready), 32'd1);
   endtask

   logic [15:0] f [NTAPS];
   logic [16:0] exp_r;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      #12;
      check_val("rst_in_ready",  32'(in_ready),  32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_data",  32'(out_data),  32'd0);
      check_val("rst_out_ovf",   32'(out_ovf),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

      f = '{16'd432, 16'd765, 16'd1, 16'd2};
      send_frame(f, 1'b0);
      get_result("basic", {1'b0, 16'd1200}, 0);

      f = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
      send_frame(f, 1'b0);
      get_result("sat_pos", {1'b1, 16'h7FFF}, 0);

      f = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
      send_frame(f, 1'b0);
      get_result("sat_neg", {1'b1, 16'h8000}, 0);

      f = '{16'hFFFE, 16'h0001, 16'h0003, 16'hFFFB};
      send_frame(f, 1'b0);
      get_result("carry", {1'b0, 16'hFFFD}, 0);

      // Backpressure: pending result must survive ignored input traffic.
      f = '{16'd100, 16'd200, 16'd300, 16'd400};
      send_frame(f, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         check_val("bp_in_ready",  32'(in_ready),  32'd0);
         check_val("bp_out_valid", 32'(out_valid), 32'd1);
         check_val("bp_out_data",  32'(out_data),  32'd1000);
      end
      @(negedge clk);
      in_valid = 1'b0;
      get_result("bp", {1'b0, 16'd1000}, 0);
      f = '{16'd10, 16'd20, 16'd30, 16'd40};
      send_frame(f, 1'b0);
      get_result("after_bp", {1'b0, 16'd100}, 0);

      // Mid-frame reset discards the partial sum.
      send_product(16'd1000, 1'b0);
      send_product(16'd1000, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_in_ready",  32'(in_ready),  32'd0);
      check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_val("mid_rst_out_data",  32'(out_data),  32'd0);
      check_val("mid_rst_out_ovf",   32'(out_ovf),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      f = '{16'd5, 16'd6, 16'd7, 16'd8};
      send_frame(f, 1'b0);
      get_result("after_rst", {1'b0, 16'd26}, 0);

      for (int fr = 0; fr < 100; fr++) begin
         for (int i = 0; i < NTAPS; i++) begin
            case ($urandom_range(3))
               0:       f[i] = 16'($urandom_range(32767, 28000));
               1:       f[i] = 16'h8000 + 16'($urandom_range(4000));
               default: f[i] = 16'($urandom);
            endcase
         end
         exp_r = ref_result(f);
         send_frame(f, 1'b1);
         get_result("rand", exp_r, int'($urandom_range(3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
